// File: rtl/sram2_port_arbiter.sv
// Round-robin arbiter sharing the single-port SRAM2 between the Gaussian writer
// and the FAST reader, with a row-level guard so reads never overtake writes.
module sram2_port_arbiter #(
    parameter int X_MAX = 5,
    parameter int Y_MAX = 5,
    localparam int XAW = $clog2(X_MAX) + 1,
    localparam int YAW = $clog2(Y_MAX) + 1,
    localparam int XMW = $clog2(X_MAX),
    localparam int YMW = $clog2(Y_MAX)
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           new_trans,
    input  logic [XMW-1:0] max_x,
    input  logic [YMW-1:0] max_y,
    input  logic           wr_req,
    input  logic [XAW-1:0] wr_x,
    input  logic [YAW-1:0] wr_y,
    input  logic [7:0]     wr_dat,
    output logic           wr_gnt,
    input  logic           rd_req,
    input  logic [XAW-1:0] rd_x,
    input  logic [YAW-1:0] rd_y,
    output logic           rd_gnt,
    output logic           rd_valid,
    output logic [7:0]     rd_dat,
    output logic [XAW-1:0] sram_x,
    output logic [YAW-1:0] sram_y,
    output logic           sram_wen,
    output logic           sram_ren,
    output logic [7:0]     sram_wdat,
    input  logic [7:0]     sram_rdat,
    output logic [YAW-1:0] rows_ready,
    output logic           frame_done
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    typedef enum logic {GNT_READ, GNT_WRITE} gnt_t;

    state_t         state, state_nxt;
    gnt_t           last_gnt;
    logic [XMW-1:0] max_x_q;
    logic [YMW-1:0] max_y_q;

    logic [YAW-1:0] full_rows;
    logic           frame_full;
    logic           wr_elig;
    logic           rd_elig;
    logic           arb_en;
    logic           last_read;

    assign full_rows  = YAW'(max_y_q) + YAW'(1);
    assign frame_full = (rows_ready == full_rows);
    // Eligibility uses the pre-update rows_ready, so a read of the row being
    // completed this cycle waits one more cycle.
    assign rd_elig    = rd_req && ((rd_y < rows_ready) || frame_full);
    assign wr_elig    = wr_req && (rows_ready <= YAW'(max_y_q));
    assign arb_en     = (state == ACTIVE) && !new_trans;
    assign last_read  = rd_gnt && (rd_x == XAW'(max_x_q)) && (rd_y == YAW'(max_y_q));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (new_trans) state_nxt = ACTIVE;
            ACTIVE:  if (last_read) state_nxt = DONE;
            DONE:    if (new_trans) state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (arb_en) begin
            if (wr_elig && rd_elig) begin
                wr_gnt = (last_gnt == GNT_READ);
                rd_gnt = (last_gnt == GNT_WRITE);
            end else begin
                wr_gnt = wr_elig;
                rd_gnt = rd_elig;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_gnt   <= GNT_READ;
            max_x_q    <= '0;
            max_y_q    <= '0;
            rows_ready <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
            if (wr_gnt) begin
                last_gnt <= GNT_WRITE;
            end else if (rd_gnt) begin
                last_gnt <= GNT_READ;
            end
            if (new_trans) begin
                max_x_q    <= max_x;
                max_y_q    <= max_y;
                rows_ready <= '0;
            end else if (wr_gnt && (wr_x == XAW'(max_x_q)) && !frame_full) begin
                rows_ready <= rows_ready + YAW'(1);
            end
        end
    end

    assign frame_done = (state == DONE);
    assign sram_wen   = wr_gnt;
    assign sram_ren   = rd_gnt;
    assign sram_wdat  = wr_gnt ? wr_dat : 8'h00;
    assign sram_x     = wr_gnt ? wr_x : (rd_gnt ? rd_x : '0);
    assign sram_y     = wr_gnt ? wr_y : (rd_gnt ? rd_y : '0);
    assign rd_dat     = sram_rdat;

endmodule

// File: tb/tb_sram2_port_arbiter.sv
// Bench for sram2_port_arbiter: directed vector table, reset sequence, and
// randomized frames checked against a frame-level reference model.
module tb_sram2_port_arbiter;

    localparam int AW = 4;
    localparam int MW = 3;

    logic          clk;
    logic          n_rst;
    logic          new_trans;
    logic [MW-1:0] max_x, max_y;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_x, wr_y, rd_x, rd_y;
    logic [7:0]    wr_dat;
    logic          wr_gnt, rd_gnt, rd_valid;
    logic [7:0]    rd_dat;
    logic [AW-1:0] sram_x, sram_y;
    logic          sram_wen, sram_ren;
    logic [7:0]    sram_wdat, sram_rdat;
    logic [AW-1:0] rows_ready;
    logic          frame_done;

    sram2_port_arbiter dut (
        .clk(clk), .n_rst(n_rst), .new_trans(new_trans),
        .max_x(max_x), .max_y(max_y),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_dat(wr_dat), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_dat(rd_dat),
        .sram_x(sram_x), .sram_y(sram_y), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_wdat(sram_wdat), .sram_rdat(sram_rdat),
        .rows_ready(rows_ready), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: read data appears the cycle after ren.
    logic [7:0] mem [16][16];
    always @(posedge clk) begin
        if (sram_wen) mem[sram_y][sram_x] <= sram_wdat;
        if (sram_ren) sram_rdat <= mem[sram_y][sram_x];
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] pix(input logic [3:0] x, input logic [3:0] y);
        return 8'h40 + 8'(y) * 8'd8 + 8'(x);
    endfunction

    typedef struct {
        logic       nt;
        logic [2:0] mx, my;
        logic       wr;
        logic [3:0] wx, wy;
        logic       rr;
        logic [3:0] rx, ry;
        logic       egw, egr, erv;
        logic [7:0] edat;
        logic [3:0] erows;
        logic       efd;
    } vec_t;

    function automatic vec_t v(input logic nt, input logic wr, input int wx, input int wy,
                               input logic rr, input int rx, input int ry,
                               input logic egw, input logic egr, input logic erv,
                               input logic [7:0] edat, input int erows);
        vec_t r;
        r.nt = nt; r.mx = 3'd4; r.my = 3'd4;
        r.wr = wr; r.wx = 4'(wx); r.wy = 4'(wy);
        r.rr = rr; r.rx = 4'(rx); r.ry = 4'(ry);
        r.egw = egw; r.egr = egr; r.erv = erv; r.edat = edat;
        r.erows = 4'(erows); r.efd = 1'b0;
        return r;
    endfunction

    localparam int NV = 20;
    vec_t vecs [NV];

    // Frame-level reference model: phase 0 idle, 1 transferring, 2 done.
    int         m_phase, m_rows, m_mx, m_my;
    bit         m_writer_last;
    bit         m_rv;
    int         m_rvx, m_rvy;
    bit         e_gw, e_gr;
    logic [7:0] exp_img [16][16];

    task automatic model_predict();
        bit full, w_ok, r_ok;
        full = (m_rows == m_my + 1);
        w_ok = wr_req && !full;
        r_ok = rd_req && ((int'(rd_y) < m_rows) || full);
        e_gw = 1'b0;
        e_gr = 1'b0;
        if (m_phase == 1 && !new_trans) begin
            if (w_ok && r_ok) begin
                e_gw = !m_writer_last;
                e_gr = m_writer_last;
            end else begin
                e_gw = w_ok;
                e_gr = r_ok;
            end
        end
    endtask

    task automatic model_advance();
        if (e_gw) exp_img[wr_y][wr_x] = wr_dat;
        m_rv = e_gr;
        m_rvx = int'(rd_x);
        m_rvy = int'(rd_y);
        if (e_gw) m_writer_last = 1'b1;
        if (e_gr) m_writer_last = 1'b0;
        if (new_trans) begin
            m_phase = 1;
            m_mx = int'(max_x);
            m_my = int'(max_y);
            m_rows = 0;
        end else begin
            if (e_gw && int'(wr_x) == m_mx && m_rows < m_my + 1) m_rows++;
            if (e_gr && int'(rd_x) == m_mx && int'(rd_y) == m_my) m_phase = 2;
        end
    endtask

    task automatic step();
        #2;
        model_predict();
        check("wr_gnt", wr_gnt, e_gw);
        check("rd_gnt", rd_gnt, e_gr);
        check("rows_ready", rows_ready, m_rows);
        check("frame_done", frame_done, m_phase == 2);
        check("rd_valid", rd_valid, m_rv);
        if (m_rv) check("rd_dat", rd_dat, exp_img[m_rvy][m_rvx]);
        check("sram_wen", sram_wen, e_gw);
        check("sram_ren", sram_ren, e_gr);
        check("sram_x", sram_x, e_gw ? wr_x : (e_gr ? rd_x : 4'd0));
        check("sram_y", sram_y, e_gw ? wr_y : (e_gr ? rd_y : 4'd0));
        check("sram_wdat", sram_wdat, e_gw ? wr_dat : 8'd0);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic run_frame(input int mx, input int my);
        int wx, wy, rx, ry, reads_left, cyc;
        bit w_pend, r_pend;
        logic [7:0] wd;
        new_trans = 1'b1; max_x = 3'(mx); max_y = 3'(my);
        wr_req = 1'b0; rd_req = 1'b0;
        step();
        new_trans = 1'b0;
        wx = 0; wy = 0; rx = 0; ry = 0; wd = 8'h00; cyc = 0;
        w_pend = 1'b0; r_pend = 1'b0;
        reads_left = 6 + $urandom_range(0, 6);
        while (m_phase != 2 && cyc < 600) begin
            if (!w_pend && $urandom_range(0, 3) != 0) begin
                w_pend = 1'b1;
                wd = 8'($urandom);
            end
            if (!r_pend && $urandom_range(0, 2) != 0) begin
                r_pend = 1'b1;
                if (reads_left > 0) begin
                    ry = $urandom_range(0, my);
                    rx = $urandom_range(0, mx);
                    if (rx == mx && ry == my) rx = 0;
                end else begin
                    rx = mx;
                    ry = my;
                end
            end
            wr_req = w_pend; wr_x = 4'(wx); wr_y = 4'(wy); wr_dat = wd;
            rd_req = r_pend; rd_x = 4'(rx); rd_y = 4'(ry);
            step();
            if (e_gw) begin
                w_pend = 1'b0;
                if (wx == mx) begin wx = 0; wy++; end
                else wx++;
            end
            if (e_gr) begin
                r_pend = 1'b0;
                reads_left--;
            end
            cyc++;
        end
        check("frame_within_budget", cyc < 600, 1'b1);
        // Writer keeps pushing a write past the last row; reader keeps asking.
        rd_req = 1'b1; rd_x = 4'(mx); rd_y = 4'(my);
        repeat (3) step();
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; new_trans = 1'b0; max_x = '0; max_y = '0;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_dat = '0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0;

        //              nt wr wx wy rr rx ry  gw gr rv dat         rows
        vecs[0]  = v(0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 8'h00,     0);
        vecs[1]  = v(0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 8'h00,     0);
        vecs[2]  = v(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 8'h00,     0);
        vecs[3]  = v(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 8'h00,     0);
        vecs[4]  = v(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 8'h00,     0);
        vecs[5]  = v(0, 1, 2, 0, 0, 0, 0,  1, 0, 0, 8'h00,     0);
        vecs[6]  = v(0, 1, 3, 0, 0, 0, 0,  1, 0, 0, 8'h00,     0);
        vecs[7]  = v(0, 1, 4, 0, 0, 0, 0,  1, 0, 0, 8'h00,     0);
        vecs[8]  = v(0, 1, 0, 1, 1, 2, 1,  1, 0, 0, 8'h00,     1);
        vecs[9]  = v(0, 1, 1, 1, 1, 2, 1,  1, 0, 0, 8'h00,     1);
        vecs[10] = v(0, 1, 2, 1, 1, 2, 1,  1, 0, 0, 8'h00,     1);
        vecs[11] = v(0, 1, 3, 1, 1, 2, 1,  1, 0, 0, 8'h00,     1);
        vecs[12] = v(0, 1, 4, 1, 1, 2, 1,  1, 0, 0, 8'h00,     1);
        vecs[13] = v(0, 0, 0, 0, 1, 2, 1,  0, 1, 0, 8'h00,     2);
        vecs[14] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, pix(2, 1), 2);
        vecs[15] = v(0, 1, 0, 2, 1, 0, 0,  1, 0, 0, 8'h00,     2);
        vecs[16] = v(0, 1, 1, 2, 1, 0, 0,  0, 1, 0, 8'h00,     2);
        vecs[17] = v(0, 1, 1, 2, 1, 1, 0,  1, 0, 1, pix(0, 0), 2);
        vecs[18] = v(0, 1, 2, 2, 1, 1, 0,  0, 1, 0, 8'h00,     2);
        vecs[19] = v(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, pix(1, 0), 2);

        repeat (2) @(posedge clk);
        #1;
        check("reset_rows_ready", rows_ready, 4'd0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        n_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            new_trans = vecs[i].nt; max_x = vecs[i].mx; max_y = vecs[i].my;
            wr_req = vecs[i].wr; wr_x = vecs[i].wx; wr_y = vecs[i].wy;
            wr_dat = pix(vecs[i].wx, vecs[i].wy);
            rd_req = vecs[i].rr; rd_x = vecs[i].rx; rd_y = vecs[i].ry;
            #2;
            check($sformatf("vec%0d_wr_gnt", i), wr_gnt, vecs[i].egw);
            check($sformatf("vec%0d_rd_gnt", i), rd_gnt, vecs[i].egr);
            check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].erv);
            check($sformatf("vec%0d_rows_ready", i), rows_ready, vecs[i].erows);
            check($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].efd);
            if (vecs[i].erv) check($sformatf("vec%0d_rd_dat", i), rd_dat, vecs[i].edat);
            @(posedge clk);
            #1;
        end

        // Reset mid-frame while a read is being granted.
        new_trans = 1'b0; wr_req = 1'b0;
        rd_req = 1'b1; rd_x = 4'd0; rd_y = 4'd1;
        #2;
        check("rst_pre_rd_gnt", rd_gnt, 1'b1);
        #1 n_rst = 1'b0;
        #1;
        check("rst_rd_gnt", rd_gnt, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rows_ready", rows_ready, 4'd0);
        check("rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        check("rst_rd_valid_after_edge", rd_valid, 1'b0);
        n_rst = 1'b1;
        wr_req = 1'b1; wr_x = 4'd0; wr_y = 4'd0;
        rd_req = 1'b1; rd_x = 4'd0; rd_y = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("post_rst%0d_wr_gnt", i), wr_gnt, 1'b0);
            check($sformatf("post_rst%0d_rd_gnt", i), rd_gnt, 1'b0);
            @(posedge clk);
            #1;
        end
        wr_req = 1'b0; rd_req = 1'b0;

        m_phase = 0; m_rows = 0; m_mx = 0; m_my = 0;
        m_writer_last = 1'b0; m_rv = 1'b0; m_rvx = 0; m_rvy = 0;

        run_frame(4, 4);
        for (int f = 0; f < 4; f++) run_frame($urandom_range(1, 4), $urandom_range(1, 4));

        // A fresh frame after DONE clears rows_ready and returns to transfer.
        new_trans = 1'b1; max_x = 3'd4; max_y = 3'd4;
        step();
        new_trans = 1'b0;
        step();
        #2;
        check("restart_rows_ready", rows_ready, 4'd0);
        check("restart_frame_done", frame_done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
